// File: rtl/rsa_pkg.sv
// Shared types for the rsa_unit job controller: FSM state encoding and owner IDs.
package rsa_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CLR  = 3'd1,
      ST_RUN  = 3'd2,
      ST_DONE = 3'd3,
      ST_REL  = 3'd4
   } rsa_state_t;

   localparam logic OWNER_GPIO = 1'b0;
   localparam logic OWNER_SPI  = 1'b1;

endpackage

// File: rtl/rsa_rr_arbiter.sv
// Two-way round-robin winner select between the GPIO and SPI requesters (combinational).
module rsa_rr_arbiter
   import rsa_pkg::*;
(
   input  logic gpio_req,
   input  logic spi_req,
   input  logic last_owner,
   output logic valid,
   output logic winner
);

   always_comb begin
      valid  = gpio_req | spi_req;
      winner = OWNER_GPIO;
      if (gpio_req && spi_req)
         winner = (last_owner == OWNER_GPIO) ? OWNER_SPI : OWNER_GPIO;
      else if (spi_req)
         winner = OWNER_SPI;
   end

endmodule

// File: rtl/rsa_job_ctrl.sv
// Shares one rsa_unit between GPIO and SPI: arbitrate, reset/enable the core, capture result.
// Optional RSA_TIMEOUT_EN compiles in a RUN-state watchdog that aborts with a sticky error.
//
// state | meaning
// IDLE  | core held in reset, waiting for a request
// CLR   | owner granted, core enabled but still in reset
// RUN   | core running, waiting for rsa_eoc
// DONE  | result captured, done pulse
// REL   | core back in reset, grant held until owner drops its request
module rsa_job_ctrl
   import rsa_pkg::*;
#(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned TIMEOUT_W   = 12,
   parameter int unsigned TIMEOUT_CYC = 4095
) (
   input  logic              clk,
   input  logic              rstb,
   input  logic              ena,
   input  logic              gpio_req,
   input  logic              spi_req,
   input  logic              abort,
   output logic              gpio_grant,
   output logic              spi_grant,
   output logic              rsa_rst_n,
   output logic              rsa_en,
   input  logic              rsa_eoc,
   input  logic [DATA_W-1:0] rsa_result,
   output logic [DATA_W-1:0] result,
   output logic              done,
   output logic              done_owner,
   output logic              busy,
   output logic              error
);

   if (TIMEOUT_CYC < 1 || TIMEOUT_CYC >= (64'd1 << TIMEOUT_W)) begin : g_bad_timeout
      $error("rsa_job_ctrl: TIMEOUT_CYC must be in [1, 2**TIMEOUT_W)");
   end

   rsa_state_t state;
   logic       last_owner;
   logic       arb_valid;
   logic       arb_winner;
   logic       owner_req;

   rsa_rr_arbiter u_arb (
      .gpio_req   (gpio_req),
      .spi_req    (spi_req),
      .last_owner (last_owner),
      .valid      (arb_valid),
      .winner     (arb_winner)
   );

   assign owner_req = (done_owner == OWNER_SPI) ? spi_req : gpio_req;

`ifdef RSA_TIMEOUT_EN
   logic [TIMEOUT_W-1:0] wdog;
   logic                 error_q;
   logic                 wdog_tc;

   assign wdog_tc = (wdog == TIMEOUT_W'(TIMEOUT_CYC - 1));
   assign error   = error_q;
`else
   assign error = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rstb) begin
         state      <= ST_IDLE;
         last_owner <= OWNER_SPI;
         gpio_grant <= 1'b0;
         spi_grant  <= 1'b0;
         rsa_rst_n  <= 1'b0;
         rsa_en     <= 1'b0;
         result     <= '0;
         done       <= 1'b0;
         done_owner <= OWNER_GPIO;
         busy       <= 1'b0;
`ifdef RSA_TIMEOUT_EN
         wdog       <= '0;
         error_q    <= 1'b0;
`endif
      end else if (ena) begin
         case (state)
            ST_IDLE: begin
               if (arb_valid) begin
                  state      <= ST_CLR;
                  gpio_grant <= (arb_winner == OWNER_GPIO);
                  spi_grant  <= (arb_winner == OWNER_SPI);
                  done_owner <= arb_winner;
                  busy       <= 1'b1;
                  rsa_en     <= 1'b1;
                  rsa_rst_n  <= 1'b0;
`ifdef RSA_TIMEOUT_EN
                  error_q    <= 1'b0;
                  wdog       <= '0;
`endif
               end
            end
            ST_CLR: begin
               if (abort) begin
                  state      <= ST_REL;
                  rsa_en     <= 1'b0;
                  last_owner <= done_owner;
               end else begin
                  state     <= ST_RUN;
                  rsa_rst_n <= 1'b1;
               end
            end
            ST_RUN: begin
               // Priority: abort, then eoc, then watchdog expiry.
               if (abort) begin
                  state      <= ST_REL;
                  rsa_en     <= 1'b0;
                  rsa_rst_n  <= 1'b0;
                  last_owner <= done_owner;
               end else if (rsa_eoc) begin
                  state  <= ST_DONE;
                  result <= rsa_result;
                  done   <= 1'b1;
                  rsa_en <= 1'b0;
`ifdef RSA_TIMEOUT_EN
               end else if (wdog_tc) begin
                  state      <= ST_REL;
                  error_q    <= 1'b1;
                  rsa_en     <= 1'b0;
                  rsa_rst_n  <= 1'b0;
                  last_owner <= done_owner;
               end else begin
                  wdog <= wdog + 1'b1;
`endif
               end
            end
            ST_DONE: begin
               state      <= ST_REL;
               done       <= 1'b0;
               rsa_rst_n  <= 1'b0;
               last_owner <= done_owner;
            end
            ST_REL: begin
               if (!owner_req) begin
                  state      <= ST_IDLE;
                  gpio_grant <= 1'b0;
                  spi_grant  <= 1'b0;
                  busy       <= 1'b0;
               end
            end
            default: begin
               state      <= ST_IDLE;
               gpio_grant <= 1'b0;
               spi_grant  <= 1'b0;
               rsa_rst_n  <= 1'b0;
               rsa_en     <= 1'b0;
               done       <= 1'b0;
               busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule
